alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Operand/control issue stage directly upstream of the 32-bit ALU.
- Accepts decoded ops from the decode stage over a valid/ready handshake and buffers them in a small FIFO.
- Translates a 3-bit opcode into the ALU's isSub / ALU_Control / comparator_control encoding and holds operands stable in registers.
- Stretches multiply ops over MUL_CYCLES clocks, because the ALU's combinational multiplier is constrained as a multicycle path.
- The result-capture stage samples the ALU result when out_valid && out_ready.

Parameters:
- DEPTH, 2, FIFO entries; power of 2, at least 2.
- MUL_CYCLES, 2, cycles a MUL op is held before out_valid; at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  op presented by decode.
- in_ready  out  1  FIFO can accept.
- in_op  in  3  000 PASS, 001 CMP, 010 ADD, 011 SUB, 100 MUL, 101-111 illegal.
- in_cmp_sel  in  2  comparator select; used by CMP only.
- in_a  in  32  operand a.
- in_b  in  32  operand b.
- alu_a  out  32  registered operand a to ALU.
- alu_b  out  32  registered operand b to ALU.
- alu_isSub  out  1  to ALU isSub.
- alu_ctrl  out  2  to ALU ALU_Control.
- alu_cmp_ctrl  out  2  to ALU comparator_control.
- out_valid  out  1  ALU result valid for current op.
- out_ready  in  1  downstream consumes.
- fifo_count  out  clog2(DEPTH)+1  FIFO occupancy.
- illegal_op  out  1  one-cycle pulse on an illegal op accepted.
- illegal_cnt  out  8  illegal-op count; see Optional Feature.

Behaviour:
- Reset (async, rst=1): FIFO empty, fifo_count=0, in_ready=1.
  - Output register empty; alu_a=alu_b=0, alu_isSub=0, alu_ctrl=00, alu_cmp_ctrl=00.
  - out_valid=0, illegal_op=0, illegal_cnt=0, state EMPTY.
  - Reset mid-HOLD or mid-VALID discards the op and all FIFO contents.
- Input handshake:
  - Accept on in_valid && in_ready; in_ready = (fifo_count != DEPTH).
  - No same-cycle pass-through when full: in_ready stays 0 even if a pop occurs that cycle.
- Illegal op: when accepted, it is not written to the FIFO and illegal_op pulses high the next cycle.
- Decode, registered at load:
  - PASS: ctrl 00, isSub 0.
  - CMP: ctrl 01, cmp_ctrl = in_cmp_sel.
  - ADD: ctrl 10, isSub 0.
  - SUB: ctrl 10, isSub 1.
  - MUL: ctrl 11, isSub 0.
  - cmp_ctrl = 00 for every op except CMP.
- FSM states: EMPTY, HOLD, VALID.
  - Load: FIFO head pops into the output register when state is EMPTY, or when state is VALID && out_ready (back-to-back).
  - Non-MUL load -> VALID.
  - MUL load with MUL_CYCLES>1 -> HOLD, counter = MUL_CYCLES-2. MUL with MUL_CYCLES=1 -> VALID.
  - HOLD: counter decrements each cycle; at 0 -> VALID. out_valid=0 in HOLD; out_ready is ignored.
  - VALID: out_valid=1; outputs stay frozen until out_ready.
  - On out_ready: load the next op if the FIFO is non-empty, else -> EMPTY. alu_* keep their last values in EMPTY.
- Latency:
  - Op accepted at edge N into an empty stage -> loaded at edge N+1.
  - Non-MUL: out_valid high after edge N+1.
  - MUL: out_valid high after edge N+MUL_CYCLES.
- Throughput: one non-MUL op per cycle with out_ready held high.
- Simultaneous push and pop: fifo_count unchanged; pointers wrap modulo DEPTH.

Optional Feature:
- Macro ALU_ISSUE_ERRCNT_EN.
- Defined: illegal_cnt increments on each accepted illegal op and saturates at 255; cleared only by rst.
- Undefined: illegal_cnt tied to 0 with no counter logic; illegal_op pulse unchanged.

Test Plan:
- Reset then a single ADD a=5 b=3, out_ready=1 -> alu_ctrl=10, isSub=0, out_valid high 2 cycles after accept for 1 cycle, alu_a=5, alu_b=3.
- SUB a=10 b=4, then CMP sel=10 back-to-back, out_ready=1 -> consecutive out_valid cycles; isSub=1 then ctrl=01 with cmp_ctrl=10.
- MUL a=7 b=6 with MUL_CYCLES=3 -> out_valid low for 2 cycles after load (HOLD), then high; ctrl=11; ALU result 42.
- out_ready=0, push 4 ops with DEPTH=2 -> 1 held in the output register, 2 in the FIFO, in_ready=0, 4th stalls. Raise out_ready -> ops drain in order.
- Illegal op 110 between two PASS ops -> illegal_op pulses once and only the 2 PASS ops appear. With ALU_ISSUE_ERRCNT_EN, illegal_cnt=1; after 300 illegal ops, 255.
- Assert rst during MUL HOLD with 1 op queued -> out_valid=0, fifo_count=0 immediately; the next op behaves as after reset.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : Issue stage ahead of the 32-bit ALU. It buffers decoded ops in a
//            FIFO, registers the ALU operands and controls, and stretches MUL
//            ops over a multicycle window.
// Options  : ALU_ISSUE_ERRCNT_EN enables the saturating illegal-op counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
  parameter int DEPTH      = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [1:0]               in_cmp_sel,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic                     alu_isSub,
  output logic [1:0]               alu_ctrl,
  output logic [1:0]               alu_cmp_ctrl,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     illegal_op,
  output logic [7:0]               illegal_cnt
);

  localparam int c_AW         = $clog2(DEPTH);
  localparam int c_CW         = c_AW + 1;
  localparam int c_HW         = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam int c_MUL_LOAD_I = (MUL_CYCLES > 1) ? (MUL_CYCLES - 2) : 0;
  localparam logic [c_HW-1:0] c_MUL_LOAD = c_HW'(c_MUL_LOAD_I);
  localparam bit c_MUL_HOLD   = (MUL_CYCLES > 1);
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  localparam logic [2:0] c_OP_PASS = 3'b000;
  localparam logic [2:0] c_OP_CMP  = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_SUB  = 3'b011;
  localparam logic [2:0] c_OP_MUL  = 3'b100;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HOLD  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [2:0]      r_op_mem  [DEPTH];
  logic [1:0]      r_sel_mem [DEPTH];
  logic [31:0]     r_a_mem   [DEPTH];
  logic [31:0]     r_b_mem   [DEPTH];
  logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [c_HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic            r_illegal_op;

  logic       w_accept, w_illegal, w_push, w_load, w_nempty;
  logic [2:0] w_head_op;
  logic [1:0] w_dec_ctrl, w_dec_cmp;
  logic       w_dec_sub;

  // Full-check uses only the registered count, so a same-cycle pop never opens in_ready.
  assign in_ready   = (r_count != c_FULL);
  assign w_accept   = in_valid && in_ready;
  assign w_illegal  = w_accept && (in_op > c_OP_MUL);
  assign w_push     = w_accept && !w_illegal;
  assign w_nempty   = (r_count != '0);
  assign w_head_op  = r_op_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign out_valid  = (r_state == S_VALID);
  assign illegal_op = r_illegal_op;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]  <= in_op;
      r_sel_mem[r_wr_ptr] <= in_cmp_sel;
      r_a_mem[r_wr_ptr]   <= in_a;
      r_b_mem[r_wr_ptr]   <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_illegal_op <= 1'b0;
    end else begin
      r_illegal_op <= w_illegal;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_dec_ctrl = 2'b00;
    w_dec_sub  = 1'b0;
    w_dec_cmp  = 2'b00;
    case (w_head_op)
      c_OP_CMP: begin
        w_dec_ctrl = 2'b01;
        w_dec_cmp  = r_sel_mem[r_rd_ptr];
      end
      c_OP_ADD: w_dec_ctrl = 2'b10;
      c_OP_SUB: begin
        w_dec_ctrl = 2'b10;
        w_dec_sub  = 1'b1;
      end
      c_OP_MUL: w_dec_ctrl = 2'b11;
      default:  w_dec_ctrl = 2'b00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_load         = 1'b0;
    case (r_state)
      S_EMPTY: w_load = w_nempty;
      S_HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = S_VALID;
        else                  w_hold_cnt_nxt = r_hold_cnt - 1'b1;
      end
      S_VALID: begin
        if (out_ready) begin
          if (w_nempty) w_load = 1'b1;
          else          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    if (w_load) begin
      if (c_MUL_HOLD && (w_head_op == c_OP_MUL)) begin
        w_state_nxt    = S_HOLD;
        w_hold_cnt_nxt = c_MUL_LOAD;
      end else begin
        w_state_nxt = S_VALID;
      end
    end
  end

  // Operands and controls change only on a load; they keep their last values in EMPTY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_isSub    <= 1'b0;
      alu_ctrl     <= 2'b00;
      alu_cmp_ctrl <= 2'b00;
    end else if (w_load) begin
      alu_a        <= r_a_mem[r_rd_ptr];
      alu_b        <= r_b_mem[r_rd_ptr];
      alu_isSub    <= w_dec_sub;
      alu_ctrl     <= w_dec_ctrl;
      alu_cmp_ctrl <= w_dec_cmp;
    end
  end

`ifdef ALU_ISSUE_ERRCNT_EN
  logic [7:0] r_illegal_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  r_illegal_cnt <= '0;
    else if (w_illegal && (r_illegal_cnt != 8'hFF)) r_illegal_cnt <= r_illegal_cnt + 1'b1;
  end

  assign illegal_cnt = r_illegal_cnt;
`else
  assign illegal_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module   : tb_alu_issue_stage
// Purpose  : Directed self-checking bench for alu_issue_stage (DEPTH=2, MUL_CYCLES=3).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_cmp_sel;
  logic [31:0] in_a, in_b;
  logic [31:0] alu_a, alu_b;
  logic        alu_isSub;
  logic [1:0]  alu_ctrl, alu_cmp_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  fifo_count;
  logic        illegal_op;
  logic [7:0]  illegal_cnt;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_stage #(.DEPTH(2), .MUL_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cmp_sel(in_cmp_sel),
    .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_isSub(alu_isSub), .alu_ctrl(alu_ctrl),
    .alu_cmp_ctrl(alu_cmp_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .illegal_op(illegal_op), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = v; in_op = op; in_cmp_sel = sel; in_a = a; in_b = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0;
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    step(); step();
    n_vec++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if ({alu_a, alu_b} !== 64'd0) begin n_err++; $display("FAIL reset_operands got %0h/%0h want 0/0", alu_a, alu_b); end
    n_vec++; if ({alu_isSub, alu_ctrl, alu_cmp_ctrl} !== 5'd0) begin n_err++; $display("FAIL reset_ctrl got %b%b%b want 00000", alu_isSub, alu_ctrl, alu_cmp_ctrl); end
    n_vec++; if ({illegal_op, illegal_cnt} !== 9'd0) begin n_err++; $display("FAIL reset_illegal got %b/%0d want 0/0", illegal_op, illegal_cnt); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_add();
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 2'b00, 32'd5, 32'd3);
    step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    n_vec++; if (out_valid !== 1'b0 || fifo_count !== 2'd1) begin n_err++; $display("FAIL add_accept got valid=%b count=%0d want 0/1", out_valid, fifo_count); end
    step();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got %b want 1", out_valid); end
    n_vec++; if (alu_ctrl !== 2'b10 || alu_isSub !== 1'b0) begin n_err++; $display("FAIL add_ctrl got ctrl=%b sub=%b want 10/0", alu_ctrl, alu_isSub); end
    n_vec++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin n_err++; $display("FAIL add_operands got %0d/%0d want 5/3", alu_a, alu_b); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_drain got %b want 0", out_valid); end
    n_vec++; if (alu_a !== 32'd5 || alu_ctrl !== 2'b10) begin n_err++; $display("FAIL add_hold_empty got a=%0d ctrl=%b want 5/10", alu_a, alu_ctrl); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 3'b011, 2'b00, 32'd10, 32'd4);
    step();
    drive(1'b1, 3'b001, 2'b10, 32'd1, 32'd2);
    step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    n_vec++; if (out_valid !== 1'b1 || alu_isSub !== 1'b1 || alu_ctrl !== 2'b10) begin n_err++; $display("FAIL b2b_sub got v=%b sub=%b ctrl=%b want 1/1/10", out_valid, alu_isSub, alu_ctrl); end
    n_vec++; if (alu_a !== 32'd10 || alu_b !== 32'd4 || alu_cmp_ctrl !== 2'b00) begin n_err++; $display("FAIL b2b_sub_ops got %0d/%0d cmp=%b want 10/4/00", alu_a, alu_b, alu_cmp_ctrl); end
    step();
    n_vec++; if (out_valid !== 1'b1 || alu_ctrl !== 2'b01 || alu_cmp_ctrl !== 2'b10 || alu_isSub !== 1'b0) begin n_err++; $display("FAIL b2b_cmp got v=%b ctrl=%b cmp=%b sub=%b want 1/01/10/0", out_valid, alu_ctrl, alu_cmp_ctrl, alu_isSub); end
    n_vec++; if (alu_a !== 32'd1 || alu_b !== 32'd2) begin n_err++; $display("FAIL b2b_cmp_ops got %0d/%0d want 1/2", alu_a, alu_b); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b want 0", out_valid); end
  endtask

  task automatic test_mul();
    logic [31:0] prod;
    out_ready = 1'b1;
    drive(1'b1, 3'b100, 2'b00, 32'd7, 32'd6);
    step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    step();
    prod = alu_a * alu_b;
    n_vec++; if (out_valid !== 1'b0 || alu_ctrl !== 2'b11) begin n_err++; $display("FAIL mul_hold1 got v=%b ctrl=%b want 0/11", out_valid, alu_ctrl); end
    n_vec++; if (prod !== 32'd42) begin n_err++; $display("FAIL mul_product got %0d want 42", prod); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul_hold2 got %b want 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || alu_ctrl !== 2'b11 || alu_isSub !== 1'b0) begin n_err++; $display("FAIL mul_valid got v=%b ctrl=%b sub=%b want 1/11/0", out_valid, alu_ctrl, alu_isSub); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul_drain got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 3'b000, 2'b00, 32'(i), 32'(i * 16));
      step();
    end
    drive(1'b1, 3'b000, 2'b00, 32'd4, 32'd64);
    n_vec++; if (in_ready !== 1'b0 || fifo_count !== 2'd2) begin n_err++; $display("FAIL bp_full got rdy=%b count=%0d want 0/2", in_ready, fifo_count); end
    n_vec++; if (out_valid !== 1'b1 || alu_a !== 32'd1) begin n_err++; $display("FAIL bp_head got v=%b a=%0d want 1/1", out_valid, alu_a); end
    step(); step();
    n_vec++; if (fifo_count !== 2'd2 || alu_a !== 32'd1 || alu_b !== 32'd16) begin n_err++; $display("FAIL bp_stall got count=%0d a=%0d b=%0d want 2/1/16", fifo_count, alu_a, alu_b); end
    out_ready = 1'b1;
    step();
    n_vec++; if (alu_a !== 32'd2 || fifo_count !== 2'd1 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_drain2 got a=%0d count=%0d rdy=%b want 2/1/1", alu_a, fifo_count, in_ready); end
    step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    n_vec++; if (alu_a !== 32'd3 || fifo_count !== 2'd1) begin n_err++; $display("FAIL bp_drain3 got a=%0d count=%0d want 3/1", alu_a, fifo_count); end
    step();
    n_vec++; if (alu_a !== 32'd4 || alu_b !== 32'd64 || out_valid !== 1'b1 || fifo_count !== 2'd0) begin n_err++; $display("FAIL bp_drain4 got a=%0d b=%0d v=%b count=%0d want 4/64/1/0", alu_a, alu_b, out_valid, fifo_count); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [7:0] exp_one, exp_sat;
`ifdef ALU_ISSUE_ERRCNT_EN
    exp_one = 8'd1; exp_sat = 8'd255;
`else
    exp_one = 8'd0; exp_sat = 8'd0;
`endif
    out_ready = 1'b1;
    drive(1'b1, 3'b000, 2'b00, 32'd11, 32'd0);
    step();
    drive(1'b1, 3'b110, 2'b00, 32'd99, 32'd99);
    n_vec++; if (illegal_op !== 1'b0) begin n_err++; $display("FAIL ill_quiet got %b want 0", illegal_op); end
    step();
    drive(1'b1, 3'b000, 2'b00, 32'd22, 32'd0);
    n_vec++; if (illegal_op !== 1'b1 || fifo_count !== 2'd0) begin n_err++; $display("FAIL ill_pulse got pulse=%b count=%0d want 1/0", illegal_op, fifo_count); end
    n_vec++; if (out_valid !== 1'b1 || alu_a !== 32'd11) begin n_err++; $display("FAIL ill_pass1 got v=%b a=%0d want 1/11", out_valid, alu_a); end
    step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    n_vec++; if (illegal_op !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL ill_gap got pulse=%b v=%b want 0/0", illegal_op, out_valid); end
    n_vec++; if (illegal_cnt !== exp_one) begin n_err++; $display("FAIL ill_cnt1 got %0d want %0d", illegal_cnt, exp_one); end
    step();
    n_vec++; if (out_valid !== 1'b1 || alu_a !== 32'd22) begin n_err++; $display("FAIL ill_pass2 got v=%b a=%0d want 1/22", out_valid, alu_a); end
    step();
    n_vec++; if (out_valid !== 1'b0 || fifo_count !== 2'd0) begin n_err++; $display("FAIL ill_drain got v=%b count=%0d want 0/0", out_valid, fifo_count); end
    drive(1'b1, 3'b111, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < 300; i++) step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    n_vec++; if (illegal_cnt !== exp_sat) begin n_err++; $display("FAIL ill_sat got %0d want %0d", illegal_cnt, exp_sat); end
    n_vec++; if (fifo_count !== 2'd0 || out_valid !== 1'b0 || illegal_op !== 1'b1) begin n_err++; $display("FAIL ill_flood got count=%0d v=%b pulse=%b want 0/0/1", fifo_count, out_valid, illegal_op); end
    step();
  endtask

  task automatic test_reset_mid_hold();
    out_ready = 1'b1;
    drive(1'b1, 3'b100, 2'b00, 32'd3, 32'd3);
    step();
    drive(1'b1, 3'b000, 2'b00, 32'd8, 32'd8);
    step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    n_vec++; if (out_valid !== 1'b0 || fifo_count !== 2'd1 || alu_ctrl !== 2'b11) begin n_err++; $display("FAIL rh_setup got v=%b count=%0d ctrl=%b want 0/1/11", out_valid, fifo_count, alu_ctrl); end
    rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || fifo_count !== 2'd0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rh_async got v=%b count=%0d rdy=%b want 0/0/1", out_valid, fifo_count, in_ready); end
    n_vec++; if (alu_a !== 32'd0 || alu_ctrl !== 2'b00) begin n_err++; $display("FAIL rh_regs got a=%0d ctrl=%b want 0/00", alu_a, alu_ctrl); end
    step();
    rst = 1'b0;
    step(); step(); step();
    n_vec++; if (out_valid !== 1'b0 || fifo_count !== 2'd0) begin n_err++; $display("FAIL rh_flushed got v=%b count=%0d want 0/0", out_valid, fifo_count); end
    drive(1'b1, 3'b010, 2'b00, 32'd9, 32'd1);
    step();
    drive(1'b0, 3'b000, 2'b00, 32'd0, 32'd0);
    step();
    n_vec++; if (out_valid !== 1'b1 || alu_a !== 32'd9 || alu_b !== 32'd1 || alu_ctrl !== 2'b10) begin n_err++; $display("FAIL rh_next got v=%b a=%0d b=%0d ctrl=%b want 1/9/1/10", out_valid, alu_a, alu_b, alu_ctrl); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rh_next_drain got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_mul();
    test_backpressure();
    test_illegal();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
